// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory load/store path.
// Imported by dmem_ls_align and dmem_ls_ctrl.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  // Widest lane offset (doubleword builds).
  localparam int OFF_W = 3;

  function automatic logic misaligned(
    input size_e          size,
    input logic [OFF_W-1:0] offset
  );
    logic r;
    unique case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = offset[0];
      SZ_W:    r = |offset[1:0];
      default: r = |offset;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ls_align.sv
// dmem_ls_align: lane extract/extend for loads, lane merge for stores.
// Purely combinational; shared with the cache fill path.
module dmem_ls_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BYTES = DATA_W / 8,
  localparam int LSB_W = $clog2(BYTES)
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [LSB_W-1:0]  offset,
  input  size_e             size,
  input  logic              uns,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wword,
  output logic [BYTES-1:0]  be
);

  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] msk;
  logic [BYTES-1:0]  bmsk;
  logic              sgn;

  // Shift the addressed lanes down, then mask and extend.
  always_comb begin
    rsh = raw >> {offset, 3'b000};
    unique case (size)
      SZ_B: begin
        msk = DATA_W'(8'hFF);
        sgn = rsh[7];
      end
      SZ_H: begin
        msk = DATA_W'(16'hFFFF);
        sgn = rsh[15];
      end
      SZ_W: begin
        msk = DATA_W'(32'hFFFF_FFFF);
        sgn = rsh[31];
      end
      default: begin
        msk = '1;
        sgn = rsh[DATA_W-1];
      end
    endcase
    rdata = (rsh & msk)
          | (~msk & {DATA_W{sgn & ~uns}});
  end

  // Byte enables for the addressed lanes.
  always_comb begin
    unique case (size)
      SZ_B:    bmsk = BYTES'(1'b1);
      SZ_H:    bmsk = BYTES'(2'b11);
      SZ_W:    bmsk = BYTES'(4'hF);
      default: bmsk = '1;
    endcase
    be = bmsk << offset;
  end

  // Merge shifted store data into the enabled lanes only.
  always_comb begin
    wsh = wdata << {offset, 3'b000};
    wword = raw;
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) wword[8*i +: 8] = wsh[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_ls_ctrl.sv
// dmem_ls_ctrl: byte-addressed data RAM with valid/ready request, registered response.
// Optional access counters (ld_count/st_count) enabled by DMEM_ACCESS_CNT_EN.
module dmem_ls_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB_W = $clog2(BYTES);
  localparam int IDX_W = ADDR_W - LSB_W;
  localparam int WORDS = 2 ** IDX_W;

  state_e            state;
  logic [3:0]        wcnt;

  logic              we_q;
  size_e             size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [WORDS];

  logic [IDX_W-1:0]  idx;
  logic [LSB_W-1:0]  off;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;
  logic [BYTES-1:0]  be;
  logic              err;
  logic              access;
  logic              st_en;

  assign req_ready = (state == IDLE);

  assign idx = addr_q[ADDR_W-1:LSB_W];
  assign off = addr_q[LSB_W-1:0];
  assign raw = mem[idx];

  // Doublewords only exist in 64-bit builds.
  assign err = misaligned(size_q, OFF_W'(off))
             || (size_q == SZ_D && DATA_W == 32);

  assign access = (state == BUSY) && (wcnt == 4'd0);
  assign st_en  = access && we_q && !err && (|be);

  dmem_ls_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .raw   (raw),
    .offset(off),
    .size  (size_q),
    .uns   (uns_q),
    .wdata (wdata_q),
    .rdata (ld_data),
    .wword (st_word),
    .be    (be)
  );

  // Capture the request; fields are only consumed while BUSY.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      we_q    <= req_we;
      size_q  <= size_e'(req_size);
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Request/wait/response sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wcnt       <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state <= BUSY;
            wcnt  <= 4'(WAIT_STATES);
          end
        end
        BUSY: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (err || we_q) ? '0 : ld_data;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array write; a reset at the access edge drops the store.
  always_ff @(posedge clk) begin
    if (rst_n && st_en) begin
      mem[idx] <= st_word;
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  // Saturating counts of successful loads and stores.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_count <= 32'd0;
      st_count <= 32'd0;
    end else if (access && !err) begin
      if (we_q) begin
        if (st_count != 32'hFFFF_FFFF) st_count <= st_count + 32'd1;
      end else begin
        if (ld_count != 32'hFFFF_FFFF) ld_count <= ld_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ls_ctrl.sv
// tb_dmem_ls_ctrl: randomized scoreboard bench for dmem_ls_ctrl.
// Builds 64-bit with counters when DMEM_ACCESS_CNT_EN is defined.
module tb_dmem_ls_ctrl;

  localparam int AW = 11;
`ifdef DMEM_ACCESS_CNT_EN
  localparam int DW = 64;
`else
  localparam int DW = 32;
`endif
  localparam int WS   = 2;
  localparam int NB   = DW / 8;
  localparam int MEMB = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0]   ld_count;
  logic [31:0]   st_count;
`endif

  dmem_ls_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .ld_count(ld_count),
    .st_count(st_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_pass = 0;

  byte unsigned mb[MEMB];
  logic [31:0]  m_ld = 0;
  logic [31:0]  m_st = 0;
  int           last_acc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s got=event exp=none", nm);
  endtask

  // Reference: little-endian byte memory, natural alignment rule.
  function automatic void model(input logic we, input logic [1:0] sz,
      input logic uns, input logic [AW-1:0] a, input logic [DW-1:0] wd,
      output logic [DW-1:0] d, output logic e);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 64'd0;
    d = '0;
    e = ((int'(a) % n) != 0) || (n > NB);
    if (e) return;
    if (we) begin
      for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*i +: 8];
      if (m_st != 32'hFFFF_FFFF) m_st = m_st + 1;
    end else begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[int'(a) + i];
      if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      d = v[DW-1:0];
      if (m_ld != 32'hFFFF_FFFF) m_ld = m_ld + 1;
    end
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
      input logic [AW-1:0] a, input logic [DW-1:0] wd,
      input bit hold, input bit track);
    bit acc;
    int guard;
    exp_t x;
    acc = 0;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    while (!acc) begin
      if (req_ready) begin
        acc = 1;
        last_acc = cyc + 1;
        if (track) begin
          model(we, sz, uns, a, wd, x.data, x.err);
          x.cyc = cyc + 2 + WS;
          q.push_back(x);
        end
      end
      @(posedge clk);
      if (!acc) begin
        guard++;
        if (guard > 50) begin
          fail("accept_timeout");
          return;
        end
        @(negedge clk);
      end
    end
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) begin
      fail("drain_timeout");
      q.delete();
    end
  endtask

  task automatic reset_checks();
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
`ifdef DMEM_ACCESS_CNT_EN
    chk("rst_ld_count", ld_count, 0);
    chk("rst_st_count", st_count, 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ld = 0;
    m_st = 0;
    q.delete();
  endtask

  task automatic cnt_checks();
`ifdef DMEM_ACCESS_CNT_EN
    chk("ld_count", ld_count, m_ld);
    chk("st_count", st_count, m_st);
`endif
  endtask

  // Monitor: pop and compare on every response pulse.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0 && cyc > q[0].cyc) begin
        fail("missing_resp");
        void'(q.pop_front());
      end
      if (rst_n && resp_valid) begin
        if (q.size() == 0) begin
          fail("unexpected_resp");
        end else begin
          x = q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(x.cyc));
          chk("resp_err", resp_err, x.err);
          chk("resp_rdata", resp_rdata, x.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int a0;
    logic [1:0] fsz;
    fsz = (DW == 64) ? 2'd3 : 2'd2;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    reset_checks();

    for (int w = 0; w < MEMB / NB; w++)
      issue(1, fsz, 0, AW'(w * NB), '0, 1, 1);

    issue(1, 2'd2, 0, 11'h010, DW'(32'hDEADBEEF), 1, 1);
    issue(0, 2'd2, 0, 11'h010, '0, 1, 1);
    issue(1, 2'd0, 0, 11'h011, DW'(8'h7F), 1, 1);
    issue(0, 2'd2, 0, 11'h010, '0, 1, 1);
    issue(0, 2'd0, 0, 11'h013, '0, 1, 1);
    issue(0, 2'd0, 1, 11'h013, '0, 1, 1);
    issue(0, 2'd1, 0, 11'h012, '0, 1, 1);
    issue(0, 2'd1, 0, 11'h011, '0, 1, 1);
    issue(1, 2'd2, 0, 11'h012, DW'(32'h55AA55AA), 1, 1);
    issue(0, 2'd2, 0, 11'h010, '0, 1, 1);
    issue(1, 2'd3, 0, 11'h008, DW'(64'h0123456789ABCDEF), 1, 1);
    issue(0, 2'd3, 0, 11'h008, '0, 1, 1);
    issue(0, 2'd2, 1, 11'h00C, '0, 1, 1);
    issue(0, 2'd3, 0, 11'h00C, '0, 1, 1);

    a0 = last_acc;
    issue(0, 2'd2, 0, 11'h010, '0, 1, 1);
    a0 = last_acc;
    issue(0, 2'd2, 0, 11'h014, '0, 1, 1);
    chk("accept_spacing", 64'(last_acc - a0), 64'(3 + WS));
    idle();
    drain();
    cnt_checks();

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), 2'($urandom), 1'($urandom),
            AW'($urandom_range(0, 127)),
            DW'({$urandom, $urandom}), 1'($urandom), 1);
    end
    idle();
    drain();
    cnt_checks();

    issue(1, 2'd2, 0, 11'h020, DW'(32'h12345678), 1, 0);
    do_reset();
    reset_checks();
    repeat (WS + 4) @(negedge clk);
    issue(0, 2'd2, 0, 11'h020, '0, 0, 1);
    drain();
    cnt_checks();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_ls_ctrl.md
Name: dmem_ls_ctrl

Overview:
Parametrised successor data memory for the processor datapath: a byte-addressed, word-organised RAM with load/store size handling. Supports byte, half, word and (64-bit builds) doubleword access, sign/zero extension, misalignment detection and configurable wait states. It uses a valid/ready request handshake and a registered response. Sits between the ALU address output and the writeback mux, replacing the single-cycle combinational-read memory.

Parameters:
ADDR_W, 11, byte-address width; word count = 2**(ADDR_W-LSB_W)
DATA_W, 32, word width; legal values 32 or 64; BYTES = DATA_W/8, LSB_W = log2(BYTES)
WAIT_STATES, 0, extra BUSY cycles before the array access (0..15)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword (DATA_W=64 only)
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal size; valid with resp_valid

Behaviour:
- Clock port is clk; reset port is rst_n. Reset is synchronous and active-low.
- Reset: state IDLE; req_ready=1 (combinational from state); resp_valid=0; resp_rdata=0; resp_err=0; wait counter=0. Array contents are not reset.
- FSM IDLE -> BUSY -> RESP -> IDLE. One request outstanding at a time.
- IDLE: on req_valid&&req_ready at edge E0, capture all req_* fields, load counter with WAIT_STATES, go to BUSY.
- BUSY: if counter!=0, decrement. If counter==0, perform the access at this edge and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency: resp_valid is high in cycle E0+2+WAIT_STATES. Throughput is one request per 3+WAIT_STATES cycles.
- Word index = addr[ADDR_W-1:LSB_W]. Lane offset = addr[LSB_W-1:0].
- Errors:
  - Half access with addr[0]=1 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - Doubleword access with addr[2:0]!=0 is an error.
  - size 11 with DATA_W=32 is an error.
  - An errored request has the same latency, suppresses the write, and returns resp_rdata=0, resp_err=1.
- Store: merge only the addressed lanes into the word; all other bytes are preserved.
- Load: extract the addressed lanes and extend to DATA_W per req_unsigned. A full-width access ignores req_unsigned.
- Response data is registered; there are no combinational paths from req_* to resp_*.
- Inputs are ignored while req_ready=0.
- Reset mid-operation: if rst_n=0 at or before the access edge, the pending store is discarded and no response is produced.
- Store then load to the same address: the load observes the new data, because accesses are strictly serialised.

Optional Feature:
DMEM_ACCESS_CNT_EN
- Defined: adds output ports ld_count[31:0] and st_count[31:0]. Each counter increments at the access edge of each non-errored load or store, saturates at 0xFFFFFFFF, and resets to 0.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - enum size_e {SZ_B, SZ_H, SZ_W, SZ_D}
  - enum state_e {IDLE, BUSY, RESP}
  - function misaligned(size, offset)
- Sub-module dmem_ls_align (combinational): takes the raw word, offset, size, unsigned flag and wdata. Produces the extended load data, the merged store word and byte-enables. It is shared with the future cache fill path.
- Storage array and FSM stay in dmem_ls_ctrl.

Test Plan:
- Reset, DATA_W=32, WAIT_STATES=0: SW 0xDEADBEEF @0x010, then LW @0x010 -> resp_valid at E0+2, rdata=0xDEADBEEF, err=0, req_ready low for 2 cycles after each accept.
- SB 0x7F @0x011 over 0xDEADBEEF, then LW @0x010 -> 0xDEAD7FEF. LB @0x013 -> 0xFFFFFFDE. LBU @0x013 -> 0x000000DE. LH @0x012 -> 0xFFFFDEAD.
- LH @0x011 and SW @0x012 -> resp_err=1, rdata=0, and a following LW @0x010 is unchanged (0xDEAD7FEF).
- WAIT_STATES=3: LW accepted at E0 -> resp_valid exactly at E0+5. req_valid held high throughout -> the next accept is at E0+6.
- SW 0x12345678 @0x020 accepted, rst_n=0 on the following cycle -> no resp_valid, and LW @0x020 after reset does not return 0x12345678 (the pre-loaded 0 remains).
- DATA_W=64 with DMEM_ACCESS_CNT_EN defined: SD 0x0123456789ABCDEF @0x008, LD -> same value. LW @0x00C -> 0x0000000001234567 when unsigned. ld_count=2, st_count=1. A misaligned LD @0x00C leaves the counts unchanged.
